rpn_evaluator: RTL and testbench
================================

# rpn_evaluator

Consumes the postfix (RPN) token stream produced by the infix-to-RPN converter and evaluates it on an internal operand stack. It emits one WIDTH-bit result, plus an error flag, per expression. Its input port uses the converter's output stb/ack handshake token-for-token, so the two blocks connect directly to form a complete calculator datapath.

## Interface
- WIDTH, 16, result and stack-entry width (≥ 8)
- DEPTH, 8, operand stack entries (≥ 2)
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- input_stb  in  1  producer holds high while a token is valid
- input_data  in  4  operand value 0..15, or operator code
- is_input_operator  in  1  1 = input_data is an operator code
- input_ack  out  1  one-cycle pulse: token consumed
- output_stb  out  1  result valid; held until acknowledged
- output_data  out  WIDTH  expression result (0 when error)
- output_error  out  1  expression was malformed
- output_ack  in  1  consumer accepts the result

## Operation
- Operator codes: 4'h0 ADD, 4'h1 SUB, 4'h2 MUL, 4'hF END ("=").
- Codes 4'h3–4'hE are reserved and are an error.
- Operands are zero-extended to WIDTH and pushed.
- Binary ops pop b (top), then a (next), and push the result.
  - ADD: a+b. SUB: a−b. MUL: low WIDTH bits of a*b.
  - All arithmetic is modulo 2^WIDTH, unsigned.
- END behaviour:
  - depth==1 and no error: output_data=top, output_error=0.
  - Otherwise: output_data=0, output_error=1.
  - In both cases the stack is cleared, the error flag is cleared, and the block enters S_OUT.
- Error conditions set a sticky err flag:
  - binary op with depth<2 (underflow);
  - operand push with depth==DEPTH (overflow);
  - reserved opcode;
  - END with depth≠1.
- While err=1, all tokens except END are acked and discarded, with no stack change.
- FSM states:
  - S_READ: wait for input_stb.
  - S_ACK: input_ack=1, token applied to stack.
  - S_OUT: output_stb=1.
- FSM transitions:
  - S_READ→S_ACK when input_stb=1. The token is registered in the same cycle.
  - S_ACK→S_OUT if the token was END, else S_ACK→S_READ.
  - S_OUT→S_READ on the cycle output_ack=1 is sampled.
- Backpressure: no token is acked while in S_OUT.

## Timing
- Reset values: input_ack=0, output_stb=0, output_data=0, output_error=0, depth=0, err=0, state=S_READ.
- Reset asserted mid-expression or during S_OUT:
  - the next edge discards the stack and any pending result;
  - output_stb drops immediately after that edge.
- Token acceptance:
  - input_stb sampled high in cycle N (S_READ) gives input_ack=1 in cycle N+1, for exactly one cycle.
  - The stack update is visible from cycle N+2.
  - The earliest next token is sampled in cycle N+2, so peak throughput is 1 token per 2 cycles.
- The producer must hold input_data and is_input_operator stable from stb-high until it sees ack. The block samples them only in S_READ.
- Result output:
  - END sampled in cycle N gives output_stb=1 from cycle N+2.
  - output_data and output_error are stable while output_stb=1.
  - output_ack sampled high in cycle M clears output_stb in cycle M+1.
  - S_READ resumes in cycle M+1, so a new token can be sampled in cycle M+1.
- output_ack while output_stb=0 is ignored.
- Simultaneous input_stb and pending output: input waits, and input_ack stays 0, until the output is acked.
- Full-stack operator: a binary op at depth==DEPTH is legal (net depth −1).

## Test plan
- Tokens 3,4,+,2,*,= with output_ack tied high → output_data=16'd14, output_error=0. Exactly 6 input_ack pulses, one per 2 cycles.
- Tokens 2,5,−,= → output_data=16'hFFFD, error=0. Then 15,15,*,15,*,15,*,= → 16'hC5C1 (50625 mod 65536), confirming wrap.
- Underflow and reserved opcode:
  - Tokens +,3,= → output_data=0, output_error=1, all three tokens acked.
  - Next expression 7,= → 7 with error=0, confirming sticky err was cleared.
- Overflow and bad END:
  - 9 operand pushes then = (DEPTH=8) → output_error=1.
  - 1,2,= → output_error=1.
- Backpressure: hold output_ack=0 for 5 cycles after a result while input_stb stays high with the next token. Required: output_stb and output_data stable, input_ack=0 throughout, and the token is acked 2 cycles after output_ack.
- Reset mid-expression:
  - Assert rst for 1 cycle after tokens 5,6. Every output is 0 on the next cycle.
  - Then 8,= → result 8, error=0. This confirms the stack was cleared.

Source files
------------

// File: rtl/rpn_evaluator.sv
// Postfix (RPN) token evaluator with an operand stack, stb/ack token input and a held result output.
// Pairs directly with the infix-to-RPN converter to form a calculator datapath.
module rpn_evaluator #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             input_stb,
  input  logic [3:0]       input_data,
  input  logic             is_input_operator,
  output logic             input_ack,
  output logic             output_stb,
  output logic [WIDTH-1:0] output_data,
  output logic             output_error,
  input  logic             output_ack
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] FULL = DW'(DEPTH);
  localparam logic [DW-1:0] ONE  = DW'(1);
  localparam logic [DW-1:0] TWO  = DW'(2);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_END = 4'hF;

  typedef enum logic [1:0] {
    S_READ,
    S_ACK,
    S_OUT
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [3:0]       r_tokData;
  logic             r_tokOp;
  logic [WIDTH-1:0] r_stack [DEPTH];
  logic [DW-1:0]    r_depth;
  logic             r_err;
  logic [WIDTH-1:0] r_outData;
  logic             r_outError;

  logic             w_isEnd;
  logic             w_isBinary;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_result;

  // Entry 0 is always the top of stack, so pushes and pops are plain shifts.
  assign w_a        = r_stack[1];
  assign w_b        = r_stack[0];
  assign w_isEnd    = r_tokOp && (r_tokData == OP_END);
  assign w_isBinary = r_tokOp && ((r_tokData == OP_ADD) || (r_tokData == OP_SUB) ||
                                  (r_tokData == OP_MUL));

  assign input_ack    = (r_state == S_ACK);
  assign output_stb   = (r_state == S_OUT);
  assign output_data  = r_outData;
  assign output_error = r_outError;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_READ;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_READ:  if (input_stb) w_nextState = S_ACK;
      S_ACK:   w_nextState = w_isEnd ? S_OUT : S_READ;
      S_OUT:   if (output_ack) w_nextState = S_READ;
      default: w_nextState = S_READ;
    endcase
  end

  always_comb begin
    w_result = '0;
    case (r_tokData)
      OP_ADD:  w_result = w_a + w_b;
      OP_SUB:  w_result = w_a - w_b;
      OP_MUL:  w_result = w_a * w_b;
      default: w_result = '0;
    endcase
  end

  // The token is captured only in S_READ; the producer holds it until ack anyway.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tokData <= '0;
      r_tokOp   <= 1'b0;
    end else if ((r_state == S_READ) && input_stb) begin
      r_tokData <= input_data;
      r_tokOp   <= is_input_operator;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_depth    <= '0;
      r_err      <= 1'b0;
      r_outData  <= '0;
      r_outError <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_stack[i] <= '0;
    end else if (r_state == S_ACK) begin
      if (w_isEnd) begin
        if ((r_depth == ONE) && !r_err) begin
          r_outData  <= r_stack[0];
          r_outError <= 1'b0;
        end else begin
          r_outData  <= '0;
          r_outError <= 1'b1;
        end
        r_depth <= '0;
        r_err   <= 1'b0;
      end else if (!r_err) begin
        if (r_tokOp) begin
          if (!w_isBinary || (r_depth < TWO)) begin
            r_err <= 1'b1;
          end else begin
            r_stack[0] <= w_result;
            for (int i = 1; i < DEPTH - 1; i++) r_stack[i] <= r_stack[i+1];
            r_depth <= r_depth - ONE;
          end
        end else if (r_depth == FULL) begin
          r_err <= 1'b1;
        end else begin
          r_stack[0] <= {{(WIDTH-4){1'b0}}, r_tokData};
          for (int i = 1; i < DEPTH; i++) r_stack[i] <= r_stack[i-1];
          r_depth <= r_depth + ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_rpn_evaluator.sv
// Directed testbench for rpn_evaluator: streams RPN token sequences and checks
// results, error flags, handshake timing, backpressure and reset behaviour.
module tb_rpn_evaluator;

  localparam logic [4:0] ADD = 5'h10;
  localparam logic [4:0] SUB = 5'h11;
  localparam logic [4:0] MUL = 5'h12;
  localparam logic [4:0] RSV = 5'h15;
  localparam logic [4:0] EQ  = 5'h1F;

  logic        clk = 1'b0;
  logic        rst;
  logic        input_stb;
  logic [3:0]  input_data;
  logic        is_input_operator;
  logic        input_ack;
  logic        output_stb;
  logic [15:0] output_data;
  logic        output_error;
  logic        output_ack;

  int          cycle = 0;
  int          checks = 0;
  int          failures = 0;
  logic [4:0]  tokQ[$];

  rpn_evaluator #(.WIDTH(16), .DEPTH(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .input_stb         (input_stb),
    .input_data        (input_data),
    .is_input_operator (is_input_operator),
    .input_ack         (input_ack),
    .output_stb        (output_stb),
    .output_data       (output_data),
    .output_error      (output_error),
    .output_ack        (output_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Streams tokQ at full rate: the next token is presented as soon as the previous ack is seen.
  task automatic applyStimulus(input string tag);
    int lastAck;
    int waited;
    lastAck = -1;
    foreach (tokQ[k]) begin
      is_input_operator = tokQ[k][4];
      input_data        = tokQ[k][3:0];
      input_stb         = 1'b1;
      waited            = 0;
      @(negedge clk);
      while (!input_ack && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      if (!input_ack) begin
        checkOutput({tag, " ack timeout"}, 32'd0, 32'd1);
        input_stb = 1'b0;
        return;
      end
      if (lastAck >= 0) checkOutput({tag, " ack spacing"}, cycle - lastAck, 32'd2);
      lastAck = cycle;
    end
    input_stb = 1'b0;
  endtask

  // Called right after the END token's ack; the result must appear on the next cycle.
  task automatic takeResult(input string tag, input logic [15:0] expData,
                            input logic expErr, input logic keepAck);
    int waited;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!output_stb && waited < 20);
    checkOutput({tag, " stb"}, output_stb, 1);
    checkOutput({tag, " latency"}, waited, 1);
    checkOutput({tag, " data"}, output_data, expData);
    checkOutput({tag, " error"}, output_error, expErr);
    output_ack = 1'b1;
    @(negedge clk);
    output_ack = keepAck;
    checkOutput({tag, " stb cleared"}, output_stb, 0);
  endtask

  initial begin
    rst               = 1'b1;
    input_stb         = 1'b0;
    input_data        = 4'h0;
    is_input_operator = 1'b0;
    output_ack        = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset input_ack", input_ack, 0);
    checkOutput("reset output_stb", output_stb, 0);
    checkOutput("reset output_data", output_data, 0);
    checkOutput("reset output_error", output_error, 0);
    rst = 1'b0;
    @(negedge clk);

    output_ack = 1'b1;
    tokQ = '{5'h03, 5'h04, ADD, 5'h02, MUL, EQ};
    applyStimulus("expr1");
    takeResult("expr1", 16'd14, 1'b0, 1'b1);
    output_ack = 1'b0;

    tokQ = '{5'h02, 5'h05, SUB, EQ};
    applyStimulus("sub wrap");
    takeResult("sub wrap", 16'hFFFD, 1'b0, 1'b0);

    tokQ = '{5'h0F, 5'h0F, MUL, 5'h0F, MUL, 5'h0F, MUL, EQ};
    applyStimulus("mul chain");
    takeResult("mul chain", 16'hC5C1, 1'b0, 1'b0);

    tokQ = '{ADD, 5'h03, EQ};
    applyStimulus("underflow");
    takeResult("underflow", 16'd0, 1'b1, 1'b0);

    tokQ = '{5'h07, EQ};
    applyStimulus("after error");
    takeResult("after error", 16'd7, 1'b0, 1'b0);

    tokQ = '{5'h01, RSV, EQ};
    applyStimulus("reserved op");
    takeResult("reserved op", 16'd0, 1'b1, 1'b0);

    tokQ = '{5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01, EQ};
    applyStimulus("overflow");
    takeResult("overflow", 16'd0, 1'b1, 1'b0);

    tokQ = '{5'h01, 5'h02, EQ};
    applyStimulus("bad end");
    takeResult("bad end", 16'd0, 1'b1, 1'b0);

    tokQ = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08,
             ADD, ADD, ADD, ADD, ADD, ADD, ADD, EQ};
    applyStimulus("full stack");
    takeResult("full stack", 16'd36, 1'b0, 1'b0);

    tokQ = '{5'h04, EQ};
    applyStimulus("backpressure");
    @(negedge clk);
    is_input_operator = 1'b0;
    input_data        = 4'h6;
    input_stb         = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp stb held", output_stb, 1);
      checkOutput("bp data held", output_data, 16'd4);
      checkOutput("bp error held", output_error, 0);
      checkOutput("bp no input_ack", input_ack, 0);
      @(negedge clk);
    end
    output_ack = 1'b1;
    @(negedge clk);
    output_ack = 1'b0;
    checkOutput("bp stb dropped", output_stb, 0);
    checkOutput("bp ack not yet", input_ack, 0);
    @(negedge clk);
    checkOutput("bp token acked", input_ack, 1);
    input_stb = 1'b0;
    tokQ = '{EQ};
    applyStimulus("bp end");
    takeResult("bp result", 16'd6, 1'b0, 1'b0);

    tokQ = '{5'h05, 5'h06};
    applyStimulus("pre reset");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid reset input_ack", input_ack, 0);
    checkOutput("mid reset output_stb", output_stb, 0);
    checkOutput("mid reset output_data", output_data, 0);
    checkOutput("mid reset output_error", output_error, 0);
    tokQ = '{5'h08, EQ};
    applyStimulus("post reset");
    takeResult("post reset", 16'd8, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
